regfile_debug: RTL and testbench
================================

# regfile_debug

Debug access engine for the 8×16-bit processor register file. It sits beside the core's register file and drives the file's read port (ra/ar) and write port (rb/write/data) while the core is stalled. On command it either dumps all registers r0..r7 out over a valid/ready stream, or loads r0..r7 from an incoming valid/ready stream. Core stalling and the port muxing between the core and this block are external; `busy` is the stall request.

## Interface
Parameters:
- NREG, 8, number of registers walked (r0..NREG-1)
- AW, 3, register index width
- DW, 16, data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising clock
- cmd_valid  in  1  command request
- cmd_op  in  1  0 = dump, 1 = load; sampled on cmd handshake
- cmd_ready  out  1  high only in IDLE
- rf_ra  out  AW  register file read index
- rf_ar  in  DW  register file read data (combinational from rf_ra)
- rf_rb  out  AW  register file write index
- rf_write  out  1  register file write enable
- rf_data  out  DW  register file write data
- in_valid  in  1  load stream word valid
- in_data  in  DW  load stream word
- in_ready  out  1  load stream ready
- out_valid  out  1  dump stream word valid
- out_data  out  DW  dump stream word (registered)
- out_last  out  1  marks the word from r[NREG-1]
- out_ready  in  1  dump stream ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at command completion

## Operation
- FSM states: IDLE, DUMP_RD, DUMP_OUT, LOAD, DONE. Index counter `idx` is AW bits.
- IDLE: cmd_ready=1. On cmd_valid: idx←0; next state is DUMP_RD (op 0) or LOAD (op 1).
- DUMP_RD: rf_ra=idx; out_data←rf_ar; out_last←(idx==NREG-1); out_valid←1; go to DUMP_OUT.
- DUMP_OUT: out_valid, out_data and out_last held stable until out_ready. On handshake: out_valid←0. If out_last, go to DONE; else idx←idx+1 and go to DUMP_RD.
- LOAD: in_ready=1; rf_rb=idx; rf_data=in_data; rf_write=in_valid (combinational). On handshake: if idx==NREG-1, go to DONE; else idx←idx+1.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Outside DUMP_RD, rf_ra=0. Outside LOAD, rf_rb=0, rf_write=0, rf_data=0, in_ready=0.
- in_valid is ignored outside LOAD. out_ready is ignored when out_valid=0. cmd_valid is ignored while busy.
- idx never wraps. Termination is by comparison with NREG-1 only.

## Timing
- Reset (reset=0 at a rising edge): state=IDLE, idx=0, out_valid=0, out_data=0, out_last=0, done=0.
  - Resulting outputs: busy=0, cmd_ready=1, rf_write=0.
- Reset mid-operation aborts the command in the same edge:
  - no rf_write occurs after that edge;
  - registers already loaded keep their values;
  - no done pulse is issued.
- Cycle 0 is the cmd handshake cycle; busy rises in cycle 1.
- Dump with out_ready held high:
  - word k is valid in cycle 2+2k, so r7 is valid with out_last=1 in cycle 16;
  - done is high in cycle 17; IDLE (cmd_ready=1) in cycle 18.
- Dump backpressure: each cycle out_ready stays low adds one cycle. out_data must not change while stalled.
- Load with in_valid held high:
  - writes r0..r7 in cycles 1..8, one write per cycle;
  - done is high in cycle 9; IDLE in cycle 10.
- Load gaps: a cycle with in_valid=0 produces no write and no idx advance.
- Register file writes take effect on the edge ending the LOAD handshake cycle.

## Test plan
- Reset: drive reset=0 for 2 cycles mid-traffic -> out_valid=0, done=0, busy=0, cmd_ready=1, rf_write=0 from the first edge.
- Dump with register file preset to r[i]=i, out_ready=1: cmd_op=0 -> out_data sequence 0..7 in cycles 2,4,…,16; out_last only on value 7; done in cycle 17.
- Dump backpressure: toggle out_ready 1010… -> same 0..7 sequence; no word dropped or duplicated; out_data stable while stalled.
- Load 0xA000+i with gaps (in_valid 1,0,1,…): cmd_op=1 -> exactly 8 rf_write pulses with rf_rb=0..7, rf_data=0xA000..0xA007; a following dump returns 0xA000..0xA007.
- Reset mid-load after 3 writes -> r0..r2 = new values, r3..r7 unchanged; no done pulse; next cmd accepted normally.
- cmd_valid held high during a dump -> exactly one command executes; second command accepted only in the IDLE cycle after done.

Source files
------------

// File: rtl/regfile_debug.sv
// Debug access engine for the processor register file: dumps r0..NREG-1 onto a
// valid/ready stream or loads them from one while the core is stalled.
module regfile_debug #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic          cmd_op,
    output logic          cmd_ready,
    output logic [AW-1:0] rf_ra,
    input  logic [DW-1:0] rf_ar,
    output logic [AW-1:0] rf_rb,
    output logic          rf_write,
    output logic [DW-1:0] rf_data,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DUMP_RD  = 3'd1,
        S_DUMP_OUT = 3'd2,
        S_LOAD     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            done_q, done_d;

    // State and output registers; reset aborts any command on the same edge
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= {AW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Next-state, index walk and dump word capture
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    idx_d   = {AW{1'b0}};
                    state_d = cmd_op ? S_LOAD : S_DUMP_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DUMP_RD: begin
                out_data_d  = rf_ar;
                out_last_d  = (idx_q == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_DUMP_RD;
                    end
                end else begin
                    state_d = S_DUMP_OUT;
                end
            end
            // Termination is by compare with the last index, so idx never wraps
            S_LOAD: begin
                if (in_valid) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
    end

    // Register-file port drive and stream handshakes decoded from current state
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        if (state_q == S_DUMP_RD) begin
            rf_ra = idx_q;
        end else begin
            rf_ra = {AW{1'b0}};
        end
        if (state_q == S_LOAD) begin
            in_ready = 1'b1;
            rf_rb    = idx_q;
            rf_data  = in_data;
            rf_write = in_valid;
        end else begin
            in_ready = 1'b0;
            rf_rb    = {AW{1'b0}};
            rf_data  = {DW{1'b0}};
            rf_write = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_debug.sv
// Self-checking bench for regfile_debug: an 8x16 register file model, a
// transaction-level scoreboard checked every cycle, and directed timing pins.
module tb_regfile_debug;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_op = 1'b0;
    logic        cmd_ready;
    logic [2:0]  rf_ra;
    logic [15:0] rf_ar;
    logic [2:0]  rf_rb;
    logic        rf_write;
    logic [15:0] rf_data;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    regfile_debug #(.NREG(8), .AW(3), .DW(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .rf_ra(rf_ra), .rf_ar(rf_ar), .rf_rb(rf_rb), .rf_write(rf_write), .rf_data(rf_data),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Environment: the core register file (not reset) and a cycle counter
    logic [15:0] rf [8];
    assign rf_ar = rf[rf_ra];
    int   cyc = 0;
    logic rst_edge = 1'b0;
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
        if (rf_write) rf[rf_rb] <= rf_data;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Behavioural model: expected register contents, expected stream words and writes
    logic [15:0] model_mem [8];
    logic [16:0] exp_out [$];
    logic [19:0] exp_wr [$];
    logic        done_due = 1'b0;
    logic        stall_v = 1'b0;
    logic [16:0] stall_w = 17'h0;
    logic [16:0] e;
    logic [19:0] w;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          cmd_cyc = 0;
    int          done_rel = -1;
    int          out_rel [$];
    int          wr_rel [$];
    int          hs_cyc [$];
    logic [15:0] got [$];

    initial begin
        forever begin
            @(negedge clock);
            if (!rst_edge) begin
                chk("rst_out_valid", out_valid, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_cmd_ready", cmd_ready, 1'b1);
                chk("rst_rf_write", rf_write, 1'b0);
                exp_out.delete();
                exp_wr.delete();
                done_due = 1'b0;
                stall_v  = 1'b0;
            end else begin
                chk("done", done, done_due);
                if (done === 1'b1) begin
                    done_cnt++;
                    done_rel = cyc - cmd_cyc;
                end
                done_due = 1'b0;
                chk("busy_vs_ready", busy, !cmd_ready);
                chk("rf_write_hs", rf_write, in_valid && in_ready);
                if (in_ready !== 1'b1) begin
                    chk("rf_rb_idle", rf_rb, 3'd0);
                    chk("rf_data_idle", rf_data, 16'h0000);
                end
                if (out_valid === 1'b1) begin
                    if (stall_v) chk("out_stable", {out_last, out_data}, stall_w);
                    if (out_ready) begin
                        if (exp_out.size() == 0) begin
                            chk("out_unexpected", out_valid, 1'b0);
                        end else begin
                            e = exp_out.pop_front();
                            chk("out_data", out_data, e[15:0]);
                            chk("out_last", out_last, e[16]);
                            if (e[16]) done_due = 1'b1;
                            got.push_back(out_data);
                            out_rel.push_back(cyc - cmd_cyc);
                        end
                        stall_v = 1'b0;
                    end else begin
                        stall_v = 1'b1;
                        stall_w = {out_last, out_data};
                    end
                end else begin
                    stall_v = 1'b0;
                end
                if (rf_write === 1'b1) begin
                    if (exp_wr.size() == 0) begin
                        chk("wr_unexpected", rf_write, 1'b0);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("rf_rb", rf_rb, w[18:16]);
                        chk("rf_data", rf_data, w[15:0]);
                        model_mem[w[18:16]] = w[15:0];
                        wr_rel.push_back(cyc - cmd_cyc);
                        if (w[19]) done_due = 1'b1;
                    end
                end
                if (cmd_valid && cmd_ready && reset) begin
                    hs_cnt++;
                    cmd_cyc = cyc;
                    hs_cyc.push_back(cyc);
                    if (!cmd_op) begin
                        for (int k = 0; k < 8; k++) exp_out.push_back({k == 7, model_mem[k]});
                    end
                end
            end
        end
    end

    task automatic issue(input logic op);
        int  n0;
        bit  ok;
        cmd_op    = op;
        cmd_valid = 1'b1;
        n0 = hs_cnt;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            if (hs_cnt > n0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        cmd_valid = 1'b0;
        if (!ok) timeout("cmd_accept");
    endtask

    task automatic wait_done(input int n0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_cnt > n0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) timeout("wait_done");
    endtask

    task automatic run_dump(input bit bp);
        int n0;
        bit ok;
        got.delete();
        out_rel.delete();
        out_ready = 1'b1;
        n0 = done_cnt;
        ok = 1'b0;
        issue(1'b0);
        for (int c = 0; c < 200; c++) begin
            out_ready = bp ? (c % 2 == 0) : 1'b1;
            @(posedge clock);
            #1;
            if (done_cnt > n0) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        if (!ok) timeout("dump_done");
    endtask

    task automatic run_load(input logic [15:0] base, input bit gaps);
        int   n0;
        int   i;
        logic hs;
        for (int k = 0; k < 8; k++) exp_wr.push_back({k == 7, 3'(k), base + 16'(k)});
        wr_rel.delete();
        n0 = done_cnt;
        issue(1'b1);
        i = 0;
        for (int c = 0; c < 200 && i < 8; c++) begin
            in_valid = gaps ? (c % 2 == 0) : 1'b1;
            in_data  = base + 16'(i);
            @(negedge clock);
            hs = in_valid && in_ready;
            @(posedge clock);
            #1;
            if (hs) i++;
        end
        in_valid = 1'b0;
        in_data  = 16'h0000;
        if (i != 8) timeout("load_words");
        wait_done(n0);
    endtask

    initial begin
        int n0;
        int d0;
        for (int k = 0; k < 8; k++) begin
            rf[k]        = 16'(k);
            model_mem[k] = 16'(k);
        end
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Dump with out_ready high: words in cycles 2,4..16, done 17, idle 18
        run_dump(1'b0);
        chk("dump_count", got.size(), 8);
        if (got.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("dump_word_cycle", out_rel[k], 2 + 2 * k);
            chk("dump_lit_r0", got[0], 16'h0000);
            chk("dump_lit_r7", got[7], 16'h0007);
        end
        chk("dump_done_cycle", done_rel, 17);
        chk("dump_idle_cycle18", cmd_ready, 1'b1);

        // Dump with out_ready toggling 1010...
        run_dump(1'b1);
        chk("bp_count", got.size(), 8);
        if (got.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("bp_word", got[k], 16'(k));
        end

        // Load held high: writes in cycles 1..8, done 9
        run_load(16'hC000, 1'b0);
        chk("load_count", wr_rel.size(), 8);
        if (wr_rel.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("load_write_cycle", wr_rel[k], 1 + k);
        end
        chk("load_done_cycle", done_rel, 9);

        // Load with gaps, then read back
        run_load(16'hA000, 1'b1);
        chk("gap_load_count", wr_rel.size(), 8);
        run_dump(1'b0);
        if (got.size() == 8) begin
            for (int k = 0; k < 8; k++) chk("readback_A", got[k], 16'hA000 + 16'(k));
        end

        // Reset after three load writes
        for (int k = 0; k < 8; k++) exp_wr.push_back({k == 7, 3'(k), 16'hB000 + 16'(k)});
        d0 = done_cnt;
        issue(1'b1);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 16'hB000 + 16'(k);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midload_no_done", done_cnt, d0);
        run_dump(1'b0);
        chk("midload_dump_count", got.size(), 8);
        if (got.size() == 8) begin
            chk("midload_r0", got[0], 16'hB000);
            chk("midload_r2", got[2], 16'hB002);
            chk("midload_r3", got[3], 16'hA003);
            chk("midload_r7", got[7], 16'hA007);
        end

        // Reset mid-dump
        d0 = done_cnt;
        out_ready = 1'b1;
        issue(1'b0);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("middump_no_done", done_cnt, d0);
        chk("middump_ready", cmd_ready, 1'b1);

        // cmd_valid held high across a whole dump
        n0 = hs_cnt;
        d0 = done_cnt;
        hs_cyc.delete();
        out_ready = 1'b1;
        cmd_op    = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            if (hs_cnt >= n0 + 2) break;
        end
        #1;
        cmd_valid = 1'b0;
        chk("held_hs_count", hs_cnt, n0 + 2);
        if (hs_cyc.size() == 2) chk("held_second_hs", hs_cyc[1] - hs_cyc[0], 18);
        wait_done(d0 + 1);
        chk("held_done_count", done_cnt, d0 + 2);

        chk("exp_out_drained", exp_out.size(), 0);
        chk("exp_wr_drained", exp_wr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
